// File: rtl/alu_op_sequencer.sv
// Initiator side of the ALU control/result interface: accepts one op request,
// drives the ALU for one cycle, then streams LO (and HI for MUL/DIV) result beats.
// Optional: define ALU_DIV0_TRAP_EN to trap DIV with B==0 as a single error beat.
module alu_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4,
  parameter int CTRLW = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OPW-1:0]   req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [CTRLW-1:0] alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_zlow,
  input  logic [WIDTH-1:0] alu_zhigh,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_hi,
  output logic             res_last,
  output logic             res_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB_LO,
    S_WB_HI
  } state_t;

  localparam logic [OPW-1:0] OP_MUL = OPW'(2);
  localparam logic [OPW-1:0] OP_DIV = OPW'(3);

  state_t           state_q, state_d;
  logic [OPW-1:0]   op_q,    op_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             wide_q,  wide_d;
  logic             err_q,   err_d;
  logic [WIDTH-1:0] zlo_q,   zlo_d;
  logic [WIDTH-1:0] zhi_q,   zhi_d;

  logic req_op_bad;
  logic op_q_valid;

  assign req_op_bad = !(int'(req_op) < CTRLW);
  assign op_q_valid = int'(op_q) < CTRLW;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    wide_d    = wide_q;
    err_d     = err_q;
    zlo_d     = zlo_q;
    zhi_d     = zhi_q;
    req_ready = 1'b0;
    alu_ctrl  = '0;
    res_valid = 1'b0;
    res_data  = '0;
    res_hi    = 1'b0;
    res_last  = 1'b0;
    res_err   = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          err_d   = req_op_bad;
          wide_d  = !req_op_bad && (req_op == OP_MUL || req_op == OP_DIV);
          state_d = S_EXEC;
`ifdef ALU_DIV0_TRAP_EN
          // Divide-by-zero never reaches the ALU: results are forced here.
          if (req_op == OP_DIV && req_b == '0) begin
            err_d   = 1'b1;
            wide_d  = 1'b0;
            zlo_d   = '0;
            zhi_d   = '0;
            state_d = S_WB_LO;
          end
`endif
        end
      end

      S_EXEC: begin
        if (op_q_valid) begin
          alu_ctrl = CTRLW'(1) << op_q;
        end
        zlo_d   = err_q  ? '0 : alu_zlow;
        zhi_d   = wide_q ? alu_zhigh : '0;
        state_d = S_WB_LO;
      end

      S_WB_LO: begin
        res_valid = 1'b1;
        res_data  = zlo_q;
        res_last  = !wide_q;
        res_err   = err_q;
        if (res_ready) begin
          state_d = wide_q ? S_WB_HI : S_IDLE;
        end
      end

      S_WB_HI: begin
        res_valid = 1'b1;
        res_hi    = 1'b1;
        res_data  = zhi_q;
        res_last  = 1'b1;
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      wide_q  <= 1'b0;
      err_q   <= 1'b0;
      zlo_q   <= '0;
      zhi_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wide_q  <= wide_d;
      err_q   <= err_d;
      zlo_q   <= zlo_d;
      zhi_q   <= zhi_d;
    end
  end

  assign alu_a = a_q;
  assign alu_b = b_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural ALU plus a transaction-level
// reference of the expected result beats, directed cases then random traffic.
module tb_alu_op_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [11:0] alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_zlow;
  logic [31:0] alu_zhigh;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_hi;
  logic        res_last;
  logic        res_err;

  int n_checks = 0;
  int n_fail   = 0;
  int ctrl_pulses;
  logic [11:0] ctrl_last;
  int alu_sel;

  alu_op_sequencer #(.WIDTH(32), .OPW(4), .CTRLW(12)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_ctrl  (alu_ctrl),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_zlow  (alu_zlow),
    .alu_zhigh (alu_zhigh),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_hi    (res_hi),
    .res_last  (res_last),
    .res_err   (res_err)
  );

  always #5 clock = ~clock;

  // Bench ALU; narrow ops return a junk high half so dropping it is observable.
  function automatic logic [63:0] alu_math(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] lo;
    case (op)
      0:  lo = a + b;
      1:  lo = a - b;
      2:  return {32'h0, a} * {32'h0, b};
      3:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      4:  lo = a >> b[4:0];
      5:  lo = a << b[4:0];
      6:  lo = (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}));
      7:  lo = (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]}));
      8:  lo = a & b;
      9:  lo = a | b;
      10: lo = -a;
      default: lo = ~a;
    endcase
    return {lo ^ 32'h5A5A_5A5A, lo};
  endfunction

  always_comb begin
    alu_sel = -1;
    for (int i = 0; i < 12; i++) begin
      if (alu_ctrl[i]) alu_sel = i;
    end
    if (alu_sel < 0) {alu_zhigh, alu_zlow} = {32'hDEAD_0000, 32'hBAD0_BAD0};
    else             {alu_zhigh, alu_zlow} = alu_math(alu_sel, alu_a, alu_b);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    if (alu_ctrl != 0) begin
      ctrl_pulses++;
      ctrl_last = alu_ctrl;
    end
  endtask

  function automatic bit is_trap(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_DIV0_TRAP_EN
    return (op == 3) && (b == 0);
`else
    return 1'b0;
`endif
  endfunction

  // One complete operation: request, latency, beats (with optional stalls), return to idle.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall, input bit rdy_high);
    logic [31:0] exp_data[2];
    bit          exp_err;
    int          nbeats;
    int          lat;
    bit          bad;
    bit          trap;
    logic [63:0] r;
    bad  = (op >= 12);
    trap = is_trap(op, b);
    r    = alu_math(int'(op), a, b);
    if (bad || trap) begin
      nbeats = 1; exp_data[0] = 0; exp_data[1] = 0; exp_err = 1'b1;
    end else if (op == 2 || op == 3) begin
      nbeats = 2; exp_data[0] = r[31:0]; exp_data[1] = r[63:32]; exp_err = 1'b0;
    end else begin
      nbeats = 1; exp_data[0] = r[31:0]; exp_data[1] = 0; exp_err = 1'b0;
    end

    ctrl_pulses = 0;
    ctrl_last   = '0;
    check("req_ready_idle", {31'b0, req_ready}, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    res_ready = rdy_high;
    tick();
    req_valid = 1'b0;
    lat = 1;
    check("req_ready_busy", {31'b0, req_ready}, 0);
    while (!res_valid && lat < 8) begin
      tick();
      lat++;
    end
    check("latency", lat, trap ? 1 : 2);
    if (!res_valid) return;

    for (int k = 0; k < nbeats; k++) begin
      check("res_valid", {31'b0, res_valid}, 1);
      check("res_data", res_data, exp_data[k]);
      check("res_hi", {31'b0, res_hi}, k);
      check("res_last", {31'b0, res_last}, (k == nbeats - 1) ? 1 : 0);
      check("res_err", {31'b0, res_err}, (k == 0) ? exp_err : 0);
      if (!rdy_high) begin
        for (int s = 0; s < stall; s++) begin
          tick();
          check("hold_valid", {31'b0, res_valid}, 1);
          check("hold_data", res_data, exp_data[k]);
          check("hold_req_ready", {31'b0, req_ready}, 0);
        end
        res_ready = 1'b1;
      end
      tick();
      if (!rdy_high) res_ready = 1'b0;
    end
    res_ready = 1'b0;
    check("done_res_valid", {31'b0, res_valid}, 0);
    check("done_req_ready", {31'b0, req_ready}, 1);
    check("ctrl_pulses", ctrl_pulses, (bad || trap) ? 0 : 1);
    check("ctrl_value", {20'b0, ctrl_last}, (bad || trap) ? 0 : (32'd1 << op));
  endtask

  task automatic check_reset_state();
    check("rst_req_ready", {31'b0, req_ready}, 1);
    check("rst_alu_ctrl", {20'b0, alu_ctrl}, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_res_valid", {31'b0, res_valid}, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_flags", {29'b0, res_hi, res_last, res_err}, 0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
    ctrl_pulses = 0; ctrl_last = '0;
    tick(); tick();
    check_reset_state();
    reset = 1'b0;
    tick();

    run_op(4'd0, 32'd5, 32'd7, 0, 1'b1);
    run_op(4'd2, 32'h0001_0000, 32'h0001_0000, 0, 1'b1);
    run_op(4'd8, 32'hF0F0_F0F0, 32'hFF00_FF00, 5, 1'b0);
    run_op(4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 1, 1'b0);

    // Reset mid-EXEC of DIV 17/5: the result must never surface.
    ctrl_pulses = 0;
    req_valid = 1'b1; req_op = 4'd3; req_a = 32'd17; req_b = 32'd5;
    tick();
    req_valid = 1'b0;
    check("exec_ctrl_div", {20'b0, alu_ctrl}, 32'h008);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state();
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_beat_after_reset", {31'b0, res_valid}, 0);
    end
    res_ready = 1'b0;
    run_op(4'd1, 32'd3, 32'd5, 0, 1'b1);
    check("sub_value_direct", 32'd3 - 32'd5, 32'hFFFF_FFFE);

    run_op(4'd3, 32'd100, 32'd0, 1, 1'b0);
    run_op(4'd3, 32'd100, 32'd7, 0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_op(op, a, b, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
